// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus bridge.
package lsu_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned TIMEOUT_DEF = 255;

  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } state_e;

  // Registered bus command held stable for the whole request
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  // Access attributes captured when leaving IDLE
  typedef struct packed {
    logic [1:0]        off;
    logic [1:0]        len;
    logic              sgn;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] off);
    return ((len == LEN_HALF) && off[0]) || ((len == LEN_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        len_i,
  input  logic              sgn_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] ld_data_o,
  output logic [DATA_W-1:0] st_word_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word_i[{off_i, 3'b000} +: 8];
  assign half_lane = word_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_o = word_i;
    st_word_o = wdata_i;
    case (len_i)
      LEN_BYTE: begin
        ld_data_o = {{24{sgn_i & byte_lane[7]}}, byte_lane};
        st_word_o = word_i;
        st_word_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      LEN_HALF: begin
        ld_data_o = {{16{sgn_i & half_lane[15]}}, half_lane};
        st_word_o = word_i;
        st_word_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        ld_data_o = word_i;
        st_word_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store unit driving a word-only ack-handshaked bus; stalls the core per access.
// Optional: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses without a bus cycle.
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [1:0]        mem_length,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  bus_cmd_t          cmd_q, cmd_d;
  acc_t              acc_q, acc_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;

  logic              live_c;
  logic              trap_c;
  logic              timeout_hit_c;
  logic [DATA_W-1:0] ld_data_c;
  logic [DATA_W-1:0] st_word_c;

  assign live_c        = (memread | memwrite) && (mem_length != LEN_NONE);
  assign timeout_hit_c = (TIMEOUT != 0) && (cnt_q == TO_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_c = is_misaligned(mem_length, addr[1:0]);
`else
  assign trap_c = 1'b0;
`endif

  lsu_lane_align u_lane (
    .word_i    (bus_rdata),
    .off_i     (acc_q.off),
    .len_i     (acc_q.len),
    .sgn_i     (acc_q.sgn),
    .wdata_i   (acc_q.wdata),
    .ld_data_o (ld_data_c),
    .st_word_o (st_word_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      cmd_q   <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    cmd_d   = cmd_q;
    acc_d   = acc_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    stall   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (live_c) begin
          stall         = 1'b1;
          cnt_d         = '0;
          acc_d.off     = addr[1:0];
          acc_d.len     = mem_length;
          acc_d.sgn     = mem_signed;
          acc_d.wdata   = wdata;
          cmd_d.addr    = {addr[ADDR_W-1:2], 2'b00};
          if (trap_c) begin
            mis_d   = 1'b1;
            rdata_d = '0;
            state_d = S_DONE;
          end else if (memwrite) begin
            req_d       = 1'b1;
            cmd_d.wdata = wdata;
            cmd_d.we    = (mem_length == LEN_WORD);
            state_d     = (mem_length == LEN_WORD) ? S_WR : S_RMW_RD;
          end else begin
            req_d    = 1'b1;
            cmd_d.we = 1'b0;
            state_d  = S_RD;
          end
        end
      end

      S_RD, S_WR, S_RMW_RD, S_RMW_WR: begin
        stall = 1'b1;
        if (bus_ack) begin
          cnt_d = '0;
          case (state_q)
            S_RD: begin
              rdata_d = ld_data_c;
              req_d   = 1'b0;
              state_d = S_DONE;
            end
            // Keep the request up and turn it into the merged write
            S_RMW_RD: begin
              cmd_d.we    = 1'b1;
              cmd_d.wdata = st_word_c;
              state_d     = S_RMW_WR;
            end
            default: begin
              req_d   = 1'b0;
              state_d = S_DONE;
            end
          endcase
        end else if (timeout_hit_c) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rdata     = rdata_q;
  assign misalign  = mis_q;
  assign bus_err   = err_q;
  assign bus_req   = req_q;
  assign bus_we    = cmd_q.we;
  assign bus_addr  = cmd_q.addr;
  assign bus_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge with a single-word bus responder (TIMEOUT=4).
module tb_lsu_bus_bridge;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memread = 1'b0, memwrite = 1'b0, mem_signed = 1'b0;
  logic [1:0]  mem_length = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall, misalign, bus_err, bus_req, bus_we, bus_ack;
  logic [31:0] seed_word = '0;
  logic        ack_rd_en = 1'b1, ack_wr_en = 1'b1;

  int          n_checks = 0, n_pass = 0;
  int          req_cyc = 0, rd_cnt = 0, wr_cnt = 0;
  logic [31:0] last_wdata = '0, last_waddr = '0;

  always #5 clk = ~clk;

  lsu_bus_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .memread(memread), .memwrite(memwrite),
    .mem_length(mem_length), .mem_signed(mem_signed), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(seed_word), .bus_ack(bus_ack)
  );

  assign bus_ack = bus_req && (bus_we ? ack_wr_en : ack_rd_en);

  always @(posedge clk) begin
    if (bus_req) req_cyc <= req_cyc + 1;
    if (bus_req && bus_ack) begin
      if (bus_we) begin
        wr_cnt     <= wr_cnt + 1;
        last_wdata <= bus_wdata;
        last_waddr <= bus_addr;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  // Drives one access from a negedge and returns stall-cycle count and DONE-cycle outputs
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] len,
                            input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                            output int n, output logic [31:0] rd_o,
                            output logic err_o, output logic mis_o);
    memread = rd; memwrite = wr; mem_length = len; mem_signed = sgn; addr = a; wdata = wd;
    #1;
    n = 0;
    while (stall && n < 50) begin
      n++;
      @(negedge clk);
      #1;
    end
    rd_o = rdata; err_o = bus_err; mis_o = misalign;
    memread = 1'b0; memwrite = 1'b0; mem_length = LEN_NONE; mem_signed = 1'b0;
    addr = '0; wdata = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus_req !== 1'b0) $display("FAIL rst_bus_req got %b exp 0", bus_req); else n_pass++;
    n_checks++; if (bus_we !== 1'b0) $display("FAIL rst_bus_we got %b exp 0", bus_we); else n_pass++;
    n_checks++; if (bus_addr !== 32'h0) $display("FAIL rst_bus_addr got %h exp 0", bus_addr); else n_pass++;
    n_checks++; if (bus_wdata !== 32'h0) $display("FAIL rst_bus_wdata got %h exp 0", bus_wdata); else n_pass++;
    n_checks++; if (rdata !== 32'h0) $display("FAIL rst_rdata got %h exp 0", rdata); else n_pass++;
    n_checks++; if ({stall, misalign, bus_err} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {stall, misalign, bus_err}); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus_req !== 1'b0) $display("FAIL idle_bus_req got %b exp 0", bus_req); else n_pass++;
  endtask

  task automatic test_load_word();
    int n; logic [31:0] r; logic e, m; int rc;
    seed_word = 32'hDEADBEEF; rc = rd_cnt;
    run_access(1'b1, 1'b0, LEN_WORD, 1'b0, 32'h100, 32'h0, n, r, e, m);
    n_checks++; if (n !== 2) $display("FAIL lw_stall_cycles got %0d exp 2", n); else n_pass++;
    n_checks++; if (r !== 32'hDEADBEEF) $display("FAIL lw_rdata got %h exp deadbeef", r); else n_pass++;
    n_checks++; if (bus_addr !== 32'h100) $display("FAIL lw_bus_addr got %h exp 00000100", bus_addr); else n_pass++;
    n_checks++; if (rd_cnt - rc !== 1) $display("FAIL lw_reads got %0d exp 1", rd_cnt - rc); else n_pass++;
    n_checks++; if (e !== 1'b0) $display("FAIL lw_err got %b exp 0", e); else n_pass++;
  endtask

  task automatic test_load_subword();
    int n; logic [31:0] r; logic e, m;
    seed_word = 32'h80FF7F01;
    run_access(1'b1, 1'b0, LEN_BYTE, 1'b1, 32'h103, 32'h0, n, r, e, m);
    n_checks++; if (r !== 32'hFFFFFF80) $display("FAIL lb_103 got %h exp ffffff80", r); else n_pass++;
    run_access(1'b1, 1'b0, LEN_BYTE, 1'b0, 32'h103, 32'h0, n, r, e, m);
    n_checks++; if (r !== 32'h00000080) $display("FAIL lbu_103 got %h exp 00000080", r); else n_pass++;
    run_access(1'b1, 1'b0, LEN_HALF, 1'b1, 32'h102, 32'h0, n, r, e, m);
    n_checks++; if (r !== 32'hFFFF80FF) $display("FAIL lh_102 got %h exp ffff80ff", r); else n_pass++;
    run_access(1'b1, 1'b0, LEN_HALF, 1'b0, 32'h102, 32'h0, n, r, e, m);
    n_checks++; if (r !== 32'h000080FF) $display("FAIL lhu_102 got %h exp 000080ff", r); else n_pass++;
    run_access(1'b1, 1'b0, LEN_BYTE, 1'b1, 32'h101, 32'h0, n, r, e, m);
    n_checks++; if (r !== 32'h0000007F) $display("FAIL lb_101 got %h exp 0000007f", r); else n_pass++;
    run_access(1'b1, 1'b0, LEN_BYTE, 1'b1, 32'h102, 32'h0, n, r, e, m);
    n_checks++; if (r !== 32'hFFFFFFFF) $display("FAIL lb_102 got %h exp ffffffff", r); else n_pass++;
    run_access(1'b1, 1'b0, LEN_HALF, 1'b1, 32'h100, 32'h0, n, r, e, m);
    n_checks++; if (r !== 32'h00007F01) $display("FAIL lh_100 got %h exp 00007f01", r); else n_pass++;
    run_access(1'b1, 1'b0, LEN_WORD, 1'b1, 32'h104, 32'h0, n, r, e, m);
    n_checks++; if (r !== 32'h80FF7F01) $display("FAIL lw_signed got %h exp 80ff7f01", r); else n_pass++;
  endtask

  task automatic test_store();
    int n, wc, rc, rq; logic [31:0] r; logic e, m;
    seed_word = 32'h11223344; wc = wr_cnt; rc = rd_cnt;
    run_access(1'b0, 1'b1, LEN_BYTE, 1'b0, 32'h101, 32'h000000AA, n, r, e, m);
    n_checks++; if (n !== 3) $display("FAIL sb_stall_cycles got %0d exp 3", n); else n_pass++;
    n_checks++; if (last_wdata !== 32'h1122AA44) $display("FAIL sb_merge got %h exp 1122aa44", last_wdata); else n_pass++;
    n_checks++; if ({rd_cnt - rc, wr_cnt - wc} !== {32'd1, 32'd1}) $display("FAIL sb_bus_ops got rd %0d wr %0d exp 1 1", rd_cnt - rc, wr_cnt - wc); else n_pass++;
    n_checks++; if (r !== 32'h80FF7F01) $display("FAIL sb_rdata_hold got %h exp 80ff7f01", r); else n_pass++;
    run_access(1'b0, 1'b1, LEN_HALF, 1'b0, 32'h102, 32'h1234BEEF, n, r, e, m);
    n_checks++; if (last_wdata !== 32'hBEEF3344) $display("FAIL sh_merge got %h exp beef3344", last_wdata); else n_pass++;
    run_access(1'b0, 1'b1, LEN_BYTE, 1'b0, 32'h103, 32'hFFFFFF55, n, r, e, m);
    n_checks++; if (last_wdata !== 32'h55223344) $display("FAIL sb_103_merge got %h exp 55223344", last_wdata); else n_pass++;
    rc = rd_cnt;
    run_access(1'b0, 1'b1, LEN_WORD, 1'b0, 32'h104, 32'hCAFEF00D, n, r, e, m);
    n_checks++; if (n !== 2) $display("FAIL sw_stall_cycles got %0d exp 2", n); else n_pass++;
    n_checks++; if ({last_wdata, last_waddr} !== {32'hCAFEF00D, 32'h104}) $display("FAIL sw_write got %h@%h exp cafef00d@00000104", last_wdata, last_waddr); else n_pass++;
    n_checks++; if (rd_cnt !== rc) $display("FAIL sw_no_read got %0d exp %0d", rd_cnt, rc); else n_pass++;
    rq = req_cyc;
    run_access(1'b0, 1'b1, LEN_NONE, 1'b0, 32'h200, 32'h12345678, n, r, e, m);
    n_checks++; if (n !== 0) $display("FAIL none_stall got %0d exp 0", n); else n_pass++;
    n_checks++; if (req_cyc !== rq) $display("FAIL none_bus got %0d exp %0d", req_cyc, rq); else n_pass++;
    wc = wr_cnt; rc = rd_cnt;
    run_access(1'b1, 1'b1, LEN_WORD, 1'b0, 32'h108, 32'h0BADF00D, n, r, e, m);
    n_checks++; if ({wr_cnt - wc, rd_cnt - rc} !== {32'd1, 32'd0}) $display("FAIL both_prio got wr %0d rd %0d exp 1 0", wr_cnt - wc, rd_cnt - rc); else n_pass++;
    n_checks++; if (last_waddr !== 32'h108) $display("FAIL both_addr got %h exp 00000108", last_waddr); else n_pass++;
  endtask

  task automatic test_timeout();
    int n, rq; logic [31:0] r; logic e, m;
    ack_rd_en = 1'b0; rq = req_cyc;
    run_access(1'b1, 1'b0, LEN_WORD, 1'b0, 32'h100, 32'h0, n, r, e, m);
    n_checks++; if (n !== 5) $display("FAIL to_stall_cycles got %0d exp 5", n); else n_pass++;
    n_checks++; if (e !== 1'b1) $display("FAIL to_bus_err got %b exp 1", e); else n_pass++;
    n_checks++; if (r !== 32'h0) $display("FAIL to_rdata got %h exp 0", r); else n_pass++;
    n_checks++; if (req_cyc - rq !== 4) $display("FAIL to_req_cycles got %0d exp 4", req_cyc - rq); else n_pass++;
    n_checks++; if ({bus_err, bus_req, stall} !== 3'b000) $display("FAIL to_after got %b exp 000", {bus_err, bus_req, stall}); else n_pass++;
    ack_rd_en = 1'b1;
  endtask

  task automatic test_misalign();
    int n, rq, wc; logic [31:0] r; logic e, m;
    seed_word = 32'h12349678; rq = req_cyc; wc = wr_cnt;
    run_access(1'b1, 1'b0, LEN_WORD, 1'b0, 32'h102, 32'h0, n, r, e, m);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++; if (n !== 1) $display("FAIL mis_stall got %0d exp 1", n); else n_pass++;
    n_checks++; if ({m, r} !== {1'b1, 32'h0}) $display("FAIL mis_flag got %b/%h exp 1/00000000", m, r); else n_pass++;
    n_checks++; if (req_cyc !== rq) $display("FAIL mis_no_bus got %0d exp %0d", req_cyc, rq); else n_pass++;
    n_checks++; if (misalign !== 1'b0) $display("FAIL mis_pulse got %b exp 0", misalign); else n_pass++;
    run_access(1'b0, 1'b1, LEN_HALF, 1'b0, 32'h101, 32'hFFFF, n, r, e, m);
    n_checks++; if ({m, wr_cnt - wc} !== {1'b1, 32'd0}) $display("FAIL mis_sh got %b/%0d exp 1/0", m, wr_cnt - wc); else n_pass++;
`else
    n_checks++; if (n !== 2) $display("FAIL unal_lw_stall got %0d exp 2", n); else n_pass++;
    n_checks++; if ({m, r} !== {1'b0, 32'h12349678}) $display("FAIL unal_lw got %b/%h exp 0/12349678", m, r); else n_pass++;
    n_checks++; if (bus_addr !== 32'h100) $display("FAIL unal_lw_addr got %h exp 00000100", bus_addr); else n_pass++;
    run_access(1'b1, 1'b0, LEN_HALF, 1'b1, 32'h101, 32'h0, n, r, e, m);
    n_checks++; if (r !== 32'hFFFF9678) $display("FAIL unal_lh got %h exp ffff9678", r); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    int n, wc; logic [31:0] r; logic e, m;
    seed_word = 32'h11223344; ack_wr_en = 1'b0; wc = wr_cnt;
    memwrite = 1'b1; mem_length = LEN_BYTE; mem_signed = 1'b0; addr = 32'h101; wdata = 32'hAA;
    repeat (5) @(negedge clk);
    #2;
    n_checks++; if ({bus_req, bus_we, bus_wdata} !== {2'b11, 32'h1122AA44}) $display("FAIL rmw_wr_pending got %b%b %h exp 11 1122aa44", bus_req, bus_we, bus_wdata); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus_req, bus_we} !== 2'b00) $display("FAIL mid_rst_req got %b%b exp 00", bus_req, bus_we); else n_pass++;
    n_checks++; if (bus_addr !== 32'h0) $display("FAIL mid_rst_addr got %h exp 0", bus_addr); else n_pass++;
    n_checks++; if (wr_cnt !== wc) $display("FAIL mid_rst_nowrite got %0d exp %0d", wr_cnt, wc); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; ack_wr_en = 1'b1;
    run_access(1'b0, 1'b1, LEN_BYTE, 1'b0, 32'h101, 32'hAA, n, r, e, m);
    n_checks++; if (n !== 3) $display("FAIL restart_stall got %0d exp 3", n); else n_pass++;
    n_checks++; if ({wr_cnt - wc, last_wdata} !== {32'd1, 32'h1122AA44}) $display("FAIL restart_write got %0d %h exp 1 1122aa44", wr_cnt - wc, last_wdata); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_subword();
    test_store();
    test_timeout();
    test_misalign();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
